// File: rtl/sub32_4_pkg.sv
// Shared width constants for the 4-stage pipelined 32-bit subtractor.
package sub32_4_pkg;
  localparam int DATA_W  = 32;
  localparam int SLICE_W = 8;
  localparam int STAGES  = 4;
endpackage

// File: rtl/sub32_4_slice.sv
// One 8-bit subtract slice: a8 - b8 - borrow_in done as a8 + ~b8 + ~borrow_in.
module sub8_slice
  import sub32_4_pkg::*;
(
  input  logic [SLICE_W-1:0] a8,
  input  logic [SLICE_W-1:0] b8,
  input  logic               borrow_in,
  output logic [SLICE_W-1:0] d8,
  output logic               borrow_out
);

  logic [SLICE_W:0] sum;

  // Nine-bit add; the carry out is the inverted borrow.
  always_comb begin
    sum = {1'b0, a8} + {1'b0, ~b8} + {{SLICE_W{1'b0}}, ~borrow_in};
  end

  assign d8         = sum[SLICE_W-1:0];
  assign borrow_out = ~sum[SLICE_W];

endmodule

// File: rtl/sub32_4.sv
// Pipelined 32-bit subtractor: operands are registered, then one byte is
// resolved per stage, least significant first, with a global stall.
module sub32_4
  import sub32_4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              bin,
  input  logic              in_valid,
  input  logic              stop,
  output logic [DATA_W-1:0] diff,
  output logic              bout,
  output logic              out_valid
);

  localparam int SW  = SLICE_W;
  localparam int TOP = (STAGES - 1) * SLICE_W;

  // Operand capture register
  logic [DATA_W-1:0] a_in_q, a_in_d, b_in_q, b_in_d;
  logic              bin_in_q, bin_in_d, v_in_q, v_in_d;
  // Stage 0: byte 0 resolved
  logic [DATA_W-1:SW]   a0_q, a0_d, b0_q, b0_d;
  logic [SW-1:0]        d0_q, d0_d;
  logic                 br0_q, br0_d, v0_q, v0_d;
  // Stage 1: bytes 1..0 resolved
  logic [DATA_W-1:2*SW] a1_q, a1_d, b1_q, b1_d;
  logic [2*SW-1:0]      d1_q, d1_d;
  logic                 br1_q, br1_d, v1_q, v1_d;
  // Stage 2: bytes 2..0 resolved
  logic [DATA_W-1:TOP]  a2_q, a2_d, b2_q, b2_d;
  logic [TOP-1:0]       d2_q, d2_d;
  logic                 br2_q, br2_d, v2_q, v2_d;
  // Stage 3: full result, drives the outputs
  logic [DATA_W-1:0]    diff_q, diff_d;
  logic                 bout_q, bout_d, out_valid_q, out_valid_d;

  logic [SW-1:0] sl0_d, sl1_d, sl2_d, sl3_d;
  logic          sl0_bo, sl1_bo, sl2_bo, sl3_bo;

  sub8_slice u_slice0 (.a8(a_in_q[SW-1:0]), .b8(b_in_q[SW-1:0]), .borrow_in(bin_in_q),
                       .d8(sl0_d), .borrow_out(sl0_bo));
  sub8_slice u_slice1 (.a8(a0_q[2*SW-1:SW]), .b8(b0_q[2*SW-1:SW]), .borrow_in(br0_q),
                       .d8(sl1_d), .borrow_out(sl1_bo));
  sub8_slice u_slice2 (.a8(a1_q[TOP-1:2*SW]), .b8(b1_q[TOP-1:2*SW]), .borrow_in(br1_q),
                       .d8(sl2_d), .borrow_out(sl2_bo));
  sub8_slice u_slice3 (.a8(a2_q), .b8(b2_q), .borrow_in(br2_q),
                       .d8(sl3_d), .borrow_out(sl3_bo));

  // Next-state: everything holds under stop; the result only updates for valid ops
  always_comb begin
    a_in_d = a_in_q;  b_in_d = b_in_q;  bin_in_d = bin_in_q;  v_in_d = v_in_q;
    a0_d = a0_q;  b0_d = b0_q;  d0_d = d0_q;  br0_d = br0_q;  v0_d = v0_q;
    a1_d = a1_q;  b1_d = b1_q;  d1_d = d1_q;  br1_d = br1_q;  v1_d = v1_q;
    a2_d = a2_q;  b2_d = b2_q;  d2_d = d2_q;  br2_d = br2_q;  v2_d = v2_q;
    diff_d = diff_q;  bout_d = bout_q;  out_valid_d = out_valid_q;
    if (!stop) begin
      a_in_d   = a;
      b_in_d   = b;
      bin_in_d = bin;
      v_in_d   = in_valid;

      a0_d  = a_in_q[DATA_W-1:SW];
      b0_d  = b_in_q[DATA_W-1:SW];
      d0_d  = sl0_d;
      br0_d = sl0_bo;
      v0_d  = v_in_q;

      a1_d  = a0_q[DATA_W-1:2*SW];
      b1_d  = b0_q[DATA_W-1:2*SW];
      d1_d  = {sl1_d, d0_q};
      br1_d = sl1_bo;
      v1_d  = v0_q;

      a2_d  = a1_q[DATA_W-1:TOP];
      b2_d  = b1_q[DATA_W-1:TOP];
      d2_d  = {sl2_d, d1_q};
      br2_d = sl2_bo;
      v2_d  = v1_q;

      out_valid_d = v2_q;
      if (v2_q) begin
        diff_d = {sl3_d, d2_q};
        bout_d = sl3_bo;
      end
    end
  end

  // Pipeline registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_in_q <= '0;  b_in_q <= '0;  bin_in_q <= 1'b0;  v_in_q <= 1'b0;
      a0_q <= '0;  b0_q <= '0;  d0_q <= '0;  br0_q <= 1'b0;  v0_q <= 1'b0;
      a1_q <= '0;  b1_q <= '0;  d1_q <= '0;  br1_q <= 1'b0;  v1_q <= 1'b0;
      a2_q <= '0;  b2_q <= '0;  d2_q <= '0;  br2_q <= 1'b0;  v2_q <= 1'b0;
      diff_q <= '0;  bout_q <= 1'b0;  out_valid_q <= 1'b0;
    end else begin
      a_in_q <= a_in_d;  b_in_q <= b_in_d;  bin_in_q <= bin_in_d;  v_in_q <= v_in_d;
      a0_q <= a0_d;  b0_q <= b0_d;  d0_q <= d0_d;  br0_q <= br0_d;  v0_q <= v0_d;
      a1_q <= a1_d;  b1_q <= b1_d;  d1_q <= d1_d;  br1_q <= br1_d;  v1_q <= v1_d;
      a2_q <= a2_d;  b2_q <= b2_d;  d2_q <= d2_d;  br2_q <= br2_d;  v2_q <= v2_d;
      diff_q <= diff_d;  bout_q <= bout_d;  out_valid_q <= out_valid_d;
    end
  end

  assign diff      = diff_q;
  assign bout      = bout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sub32_4.sv
// Bench for sub32_4: reference model of timing and results plus directed cases.
module tb_sub32_4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        bin, in_valid, stop;
  logic [31:0] diff;
  logic        bout, out_valid;

  always #5 clk = ~clk;

  sub32_4 dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .bin(bin), .in_valid(in_valid),
    .stop(stop), .diff(diff), .bout(bout), .out_valid(out_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted op is due once 4 unstalled edges have passed.
  typedef struct {
    logic [32:0] r;
    int          due;
  } op_t;

  op_t         mq[$];
  int          adv    = 0;
  logic [32:0] last_r = '0;

  function automatic logic [32:0] ref_sub(input logic [31:0] x, input logic [31:0] y,
                                          input logic c);
    return {1'b0, x} - {1'b0, y} - {32'b0, c};
  endfunction

  always @(posedge clk or negedge rst) begin
    op_t e;
    if (!rst) begin
      mq.delete();
      adv    = 0;
      last_r = '0;
    end else if (!stop) begin
      if (mq.size() > 0 && mq[0].due == adv) begin
        last_r = mq[0].r;
        void'(mq.pop_front());
      end
      adv++;
      if (in_valid) begin
        e.r   = ref_sub(a, b, bin);
        e.due = adv + 4;
        mq.push_back(e);
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    logic        ev;
    logic [32:0] er;
    ev = (mq.size() > 0) && (mq[0].due == adv);
    er = ev ? mq[0].r : last_r;
    chk("model out_valid", {63'b0, out_valid}, {63'b0, ev});
    chk("model {bout,diff}", {31'b0, bout, diff}, {31'b0, er});
  end

  task automatic run_single(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                            input logic [31:0] ed, input logic eb, input string nm);
    int k;
    @(negedge clk);
    a = ta; b = tb_; bin = tc; in_valid = 1'b1; stop = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    chk({nm, " latency"}, k, 4);
    chk({nm, " diff"}, diff, ed);
    chk({nm, " bout"}, bout, eb);
  endtask

  task automatic b2b_issue();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = 32'h10000000 + i; b = 32'h1; bin = 1'b1; in_valid = 1'b1; stop = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic b2b_collect();
    int w;
    w = 0;
    @(posedge clk); #1;
    while (!out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("b2b start", out_valid, 1);
    for (int j = 0; j < 8; j++) begin
      chk("b2b valid", out_valid, 1);
      chk("b2b diff", diff, 32'h0FFFFFFE + j);
      @(posedge clk); #1;
    end
    chk("b2b gap", out_valid, 0);
  endtask

  task automatic stall_test();
    logic        pat[7];
    logic [32:0] vals[3];
    int          vi;
    pat  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vals = '{33'h0_000000FF, 33'h0_000001FE, 33'h1_FFFFFFFE};
    vi   = 0;
    @(negedge clk); a = 32'h100; b = 32'h1; bin = 1'b0; in_valid = 1'b1; stop = 1'b0;
    @(negedge clk); a = 32'h200; b = 32'h1; bin = 1'b1;
    @(negedge clk); a = 32'h5;   b = 32'h7; bin = 1'b0;
    @(negedge clk); a = 32'hDEADBEEF; b = 32'h1234; bin = 1'b1; stop = 1'b1;
    for (int t = 3; t <= 9; t++) begin
      @(posedge clk); #1;
      chk("stall valid pattern", out_valid, pat[t-3]);
      if (pat[t-3] && vi < 3) begin
        chk("stall result", {31'b0, bout, diff}, {31'b0, vals[vi]});
        vi++;
      end
      @(negedge clk);
      if (t == 4) begin
        stop = 1'b0; in_valid = 1'b0;
      end
    end
  endtask

  task automatic reset_test();
    @(negedge clk); a = 32'h11111111; b = 32'h1; bin = 1'b0; in_valid = 1'b1; stop = 1'b0;
    @(negedge clk); a = 32'h22222222;
    @(negedge clk); a = 32'h33333333;
    @(negedge clk); in_valid = 1'b0;
    #2 rst = 1'b0; stop = 1'b1;
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset diff", diff, 0);
    chk("reset bout", bout, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset held out_valid", out_valid, 0);
    chk("reset held diff", diff, 0);
    @(negedge clk); rst = 1'b1; stop = 1'b0;
    run_single(32'h10101011, 32'h01000001, 1'b1, 32'h0F10100F, 1'b0, "post-reset");
  endtask

  task automatic random_test();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      bin      = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 3) != 0);
      stop     = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk); in_valid = 1'b0; stop = 1'b0;
    repeat (12) @(negedge clk);
    chk("random drain empty", mq.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; a = '0; b = '0; bin = 1'b0; in_valid = 1'b0; stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("initial out_valid", out_valid, 0);
    chk("initial diff", diff, 0);
    chk("initial bout", bout, 0);
    @(negedge clk); rst = 1'b1;

    run_single(32'h00000010, 32'h00000001, 1'b0, 32'h0000000F, 1'b0, "basic");
    run_single(32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, "wrap");
    run_single(32'h00010000, 32'h00000000, 1'b1, 32'h0000FFFF, 1'b0, "ripple");
    run_single(32'h00000005, 32'h00000005, 1'b1, 32'hFFFFFFFF, 1'b1, "equal+bin");

    fork
      b2b_issue();
      b2b_collect();
    join
    repeat (2) @(negedge clk);

    stall_test();
    repeat (2) @(negedge clk);

    reset_test();
    repeat (2) @(negedge clk);

    random_test();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sub32_4.md
SUB32_4 -- requirements
Module: sub32_4

Interface
REQ-001 Parameters: none; widths come from the shared package constants.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low; the block is in reset while rst=0.
REQ-004 a  input  32  minuend.
REQ-005 b  input  32  subtrahend.
REQ-006 bin  input  1  borrow-in; computes a - b - bin.
REQ-007 in_valid  input  1  operands valid this cycle.
REQ-008 stop  input  1  pipeline stall; 1 freezes all stages.
REQ-009 diff  output  32  registered difference.
REQ-010 bout  output  1  registered borrow-out (1 when a < b + bin, unsigned).
REQ-011 out_valid  output  1  diff/bout valid this cycle.

Function
REQ-012 Four pipeline stages SHALL be used; stage k (k=0..3) resolves bits [8k+7:8k] using the borrow from stage k-1; stage 0 uses bin.
REQ-013 Per slice: {carry, d} = a_slice + ~b_slice + ~borrow_in (9 bits); borrow_out = ~carry.
REQ-014 Each stage SHALL carry forward: the unresolved upper operand bytes, the resolved lower diff bytes, one borrow bit and one valid bit.
REQ-015 Latency SHALL be exactly 4 unstalled cycles: operands sampled at edge N with in_valid=1 and stop=0 appear on diff/bout with out_valid=1 after edge N+4.
REQ-016 Throughput SHALL be one operation per cycle; back-to-back in_valid SHALL not stall.
REQ-017 stop=1 at an edge: every stage register, including the outputs, SHALL hold its value; a/b/bin/in_valid are ignored that edge.
REQ-018 stop=0 and in_valid=0: a bubble enters stage 0, and the stage valid bit is 0.
REQ-019 out_valid SHALL be the stage-3 valid bit; diff/bout SHALL hold their last value when out_valid=0, with no requirement on their contents.
REQ-020 Subtraction SHALL wrap modulo 2^32 (0 - 1 = 0xFFFFFFFF, bout=1).
REQ-021 When stop deasserts, the pipeline SHALL resume exactly where it froze, with no operation lost or duplicated.

Reset
REQ-022 rst=0 SHALL immediately clear all stage registers: diff=0, bout=0, out_valid=0, all valid bits=0.
REQ-023 Reset mid-operation SHALL discard all in-flight operations; stop is ignored while rst=0.
REQ-024 The first operation sampled after rst returns to 1 SHALL complete with the normal 4-cycle latency.

Structure
REQ-025 The shared package SHALL hold DATA_W=32, SLICE_W=8 and STAGES=4.
REQ-026 The combinational sub-module sub8_slice SHALL compute (a8, b8, borrow_in) -> (d8, borrow_out); it is instantiated once per stage.
REQ-027 No combinational path SHALL run from inputs to outputs.

Verification
REQ-028 a=0x00000010, b=0x00000001, bin=0 -> diff=0x0000000F, bout=0, out_valid exactly 4 cycles later.
REQ-029 a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, bout=1; a=0x00010000, b=0, bin=1 -> diff=0x0000FFFF, bout=0 (borrow ripples across 2 slices).
REQ-030 8 back-to-back ops (a=0x10000000+i, b=1, bin=1) -> 8 consecutive out_valid cycles with diff=0x0FFFFFFE+i.
REQ-031 stop=1 for 2 cycles with 3 ops in flight -> outputs frozen, no valid change; each op emerges 2 cycles late, in order, with correct values.
REQ-032 rst=0 pulse with 3 ops in flight -> diff=0, bout=0, out_valid=0 immediately, none of the 3 ops ever appear; a post-reset op (a=0x10101011, b=0x01000001, bin=1 -> diff=0x0F10100F, bout=0) appears 4 cycles after sampling.
REQ-033 Randomized stream with random stop/in_valid against a reference model {bout,diff} = ({1'b0,a} - b - bin) -> zero mismatches, in-order delivery.
